req_arbiter4: RTL and testbench



---
 rtl/arb_pkg.sv | 26 ++
 rtl/prio_pick4.sv | 32 +++
 rtl/req_arbiter4.sv | 127 ++++++++++++
 tb/tb_req_arbiter4.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester arbiter.
// Holds the FSM state encoding, requester sizing and a one-hot to index encoder.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // OR-reduction of set positions; exact for one-hot or zero inputs.
    function automatic logic [ID_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational rotated priority picker used by both arbitration modes.
// Position (start+3) mod 4 is searched first, then downward, so start=0 means index 3 wins.
module prio_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] elig,
    input  logic [ID_W-1:0]  start,
    output logic [N_REQ-1:0] pick_oh,
    output logic [ID_W-1:0]  pick_id,
    output logic             any
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        pick_oh = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'(k) + start;
            if (!w_found && elig[w_idx]) begin
                pick_oh[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign pick_id = oh_to_idx(pick_oh);
    assign any     = |elig;

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter with hold-until-release grants, a hold watchdog and a one-cycle turnaround.
// Fixed priority (index 3 highest) by default; define ARB_ROUND_ROBIN_EN for rotating priority.
module req_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gntId;
    logic             r_gntValid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_holdCnt;
    logic [N_REQ-1:0] r_mask;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_pickIn;
    logic [ID_W-1:0]  w_start;
    logic [N_REQ-1:0] w_pickOh;
    logic [ID_W-1:0]  w_pickId;
    logic             w_any;
    logic [N_REQ-1:0] w_grantOh;
    logic [ID_W-1:0]  w_grantId;
    logic             w_ownerReq;
    logic             w_holdLast;

    assign w_elig = req & ~r_mask;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_lastId;

    // Bit-reversing the vector turns the picker's downward scan into the upward
    // search last_id+1, last_id+2, ... that rotating priority needs.
    assign w_pickIn  = {w_elig[0], w_elig[1], w_elig[2], w_elig[3]};
    assign w_start   = ID_W'(N_REQ - 1) - r_lastId;
    assign w_grantOh = {w_pickOh[0], w_pickOh[1], w_pickOh[2], w_pickOh[3]};
    assign w_grantId = ID_W'(N_REQ - 1) - w_pickId;
`else
    assign w_pickIn  = w_elig;
    assign w_start   = '0;
    assign w_grantOh = w_pickOh;
    assign w_grantId = w_pickId;
`endif

    prio_pick4 u_pick (
        .elig    (w_pickIn),
        .start   (w_start),
        .pick_oh (w_pickOh),
        .pick_id (w_pickId),
        .any     (w_any)
    );

    assign w_ownerReq = req[r_gntId];
    assign w_holdLast = (r_holdCnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gntId    <= '0;
            r_gntValid <= 1'b0;
            r_timeout  <= 1'b0;
            r_holdCnt  <= '0;
            r_mask     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastId   <= ID_W'(N_REQ - 1);
`endif
        end else begin
            r_timeout <= 1'b0;
            r_mask    <= r_mask & req;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_grantOh;
                        r_gntId    <= w_grantId;
                        r_gntValid <= 1'b1;
                        r_holdCnt  <= '0;
                        r_state    <= GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                        r_lastId   <= w_grantId;
`endif
                    end
                end
                GRANT: begin
                    // A voluntary drop wins over the watchdog on the same edge.
                    if (!w_ownerReq) begin
                        r_gnt      <= '0;
                        r_gntId    <= '0;
                        r_gntValid <= 1'b0;
                        r_state    <= RELEASE;
                    end else if (w_holdLast) begin
                        r_gnt      <= '0;
                        r_gntId    <= '0;
                        r_gntValid <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_mask     <= (r_mask & req) | r_gnt;
                        r_state    <= RELEASE;
                    end else if (r_holdCnt != CNT_W'(MAX_HOLD)) begin
                        r_holdCnt  <= r_holdCnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gntId;
    assign gnt_valid = r_gntValid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter4.sv
// Self-checking bench for req_arbiter4: directed scenarios plus random requests against a cycle model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_req_arbiter4;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state: owner index (-1 = none), cycles granted so far,
    // whether the turnaround cycle is in progress, timed-out requesters.
    int         mOwner;
    int         mHeld;
    int         mLast;
    bit         mRel;
    logic [3:0] mMask;
    logic       mTo;

    req_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pickNext(input logic [3:0] e);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (e[(mLast + k) % 4]) return (mLast + k) % 4;
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (e[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mHeld  = 0;
        mLast  = 3;
        mRel   = 1'b0;
        mMask  = 4'b0000;
        mTo    = 1'b0;
    endtask

    task automatic modelStep(input logic [3:0] r);
        logic [3:0] nextMask;
        int p;
        nextMask = mMask & r;
        mTo      = 1'b0;
        if (mRel) begin
            mRel = 1'b0;
        end else if (mOwner < 0) begin
            p = pickNext(r & ~mMask);
            if (p >= 0) begin
                mOwner = p;
                mHeld  = 1;
                mLast  = p;
            end
        end else if (!r[mOwner]) begin
            mOwner = -1;
            mRel   = 1'b1;
        end else if (mHeld == MAX_HOLD) begin
            nextMask[mOwner] = 1'b1;
            mTo    = 1'b1;
            mOwner = -1;
            mRel   = 1'b1;
        end else begin
            mHeld++;
        end
        mMask = nextMask;
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] eGnt;
        eGnt = 4'b0000;
        if (mOwner >= 0) eGnt[mOwner] = 1'b1;
        checkVal({tag, ".gnt"},       8'(gnt),       8'(eGnt));
        checkVal({tag, ".gnt_id"},    8'(gnt_id),    (mOwner >= 0) ? 8'(mOwner) : 8'd0);
        checkVal({tag, ".gnt_valid"}, 8'(gnt_valid), 8'(mOwner >= 0));
        checkVal({tag, ".timeout"},   8'(timeout),   8'(mTo));
    endtask

    // Drive req after a falling edge, let one rising edge sample it, check at the next falling edge.
    task automatic applyStimulus(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        modelStep(r);
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cntG;
        int cntT;
        int rrOrder[5];
        logic [3:0] r;

        rrOrder = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req   = 4'b0000;
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Priority among simultaneous requests, then turnaround to the next owner.
        applyStimulus(4'b1011, "prioA");
`ifndef ARB_ROUND_ROBIN_EN
        checkVal("prioGnt3", 8'(gnt), 8'h08);
`endif
        applyStimulus(4'b1011, "prioB");
        applyStimulus(4'b0011, "prioDrop");
        applyStimulus(4'b0011, "prioTurn");
        applyStimulus(4'b0011, "prioNext");
`ifndef ARB_ROUND_ROBIN_EN
        checkVal("prioGnt1", 8'(gnt), 8'h02);
        checkVal("prioId1", 8'(gnt_id), 8'h01);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, "idle1");

        // A higher request arriving mid-grant must not preempt the owner.
        applyStimulus(4'b0001, "preA");
        applyStimulus(4'b1001, "preB");
        applyStimulus(4'b1001, "preC");
        checkVal("noPreempt", 8'(gnt), 8'h01);
        applyStimulus(4'b1000, "preDrop");
        applyStimulus(4'b1000, "preTurn");
        applyStimulus(4'b1000, "preNew");
        checkVal("preNewOwner", 8'(gnt), 8'h08);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, "idle2");

        // Watchdog: exactly MAX_HOLD grant cycles, one timeout pulse, no re-grant while held.
        cntG = 0;
        cntT = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b0001, "toHold");
            if (gnt[0]) cntG++;
            if (timeout) cntT++;
        end
        checkVal("toGntCycles", 8'(cntG), 8'(MAX_HOLD));
        checkVal("toPulses", 8'(cntT), 8'd1);
        applyStimulus(4'b0000, "toDrop");
        applyStimulus(4'b0001, "toReq");
        checkVal("toRegrant", 8'(gnt), 8'h01);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, "idle3");

        // Owner drops on the very edge the watchdog would fire.
        for (int i = 0; i < MAX_HOLD; i++) applyStimulus(4'b0001, "tieHold");
        applyStimulus(4'b0000, "tieDrop");
        checkVal("tieTimeout", 8'(timeout), 8'd0);
        applyStimulus(4'b0001, "tieTurn");
        applyStimulus(4'b0001, "tieReq");
        checkVal("tieRegrant", 8'(gnt), 8'h01);

        // Reset asserted between edges while a grant is live.
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, "idle4");
        applyStimulus(4'b0100, "rstGrant");
        checkVal("rstPre", 8'(gnt), 8'h04);
        doReset();
        applyStimulus(4'b0100, "rstAfter");
        checkVal("rstRegrant", 8'(gnt), 8'h04);

`ifdef ARB_ROUND_ROBIN_EN
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, "rrGrant");
            checkVal("rrOrder", 8'(gnt_id), 8'(rrOrder[k]));
            r = 4'b1111;
            r[rrOrder[k]] = 1'b0;
            applyStimulus(r, "rrDrop");
            applyStimulus(4'b1111, "rrTurn");
        end
`endif

        // Random traffic; requests tend to persist so grants last and timeouts occur.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            applyStimulus(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
